program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have one parameter per line (name, default, meaning): ADDR_W, 8, instruction-memory address width; INSTR_W, 10, instruction width.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- last_addr  in  8  address of the final word to load; latched on accepted start.
- byte_in  in  8  incoming program byte.
- byte_valid  in  1  byte_in holds a valid byte.
- byte_ready  out  1  loader accepts byte_in this cycle.
- mem_we  out  1  write strobe to instruction memory.
- mem_addr  out  8  write address.
- mem_wdata  out  10  instruction word to write.
- cpu_hold  out  1  processor must not fetch while high.
- done  out  1  one-cycle pulse when the load completes.
- format_err  out  1  sticky flag for a malformed high byte.

Function
REQ-003 The block SHALL implement the FSM states IDLE, GET_LO, GET_HI, WRITE and FINISH.
REQ-004 In IDLE, start=1 SHALL latch last_addr, clear addr to 0, clear format_err, and go to GET_LO on the next edge; start=0 SHALL keep the FSM in IDLE.
REQ-005 The block SHALL ignore start in every state except IDLE.
REQ-006 byte_ready SHALL be 1 exactly when the state is GET_LO or GET_HI, and 0 in all other states.
REQ-007 A byte SHALL be accepted only on an edge where byte_valid=1 and byte_ready=1; with byte_valid=0 the state SHALL hold indefinitely.
REQ-008 In GET_LO, an accepted byte SHALL be stored as word bits [7:0], and the FSM SHALL go to GET_HI.
REQ-009 In GET_HI, an accepted byte's bits [1:0] SHALL be stored as word bits [9:8], and the FSM SHALL go to WRITE.
REQ-010 If the high byte's bits [7:2] are nonzero, the block SHALL set format_err to 1 and still write the word.
REQ-011 WRITE SHALL last exactly one cycle, with mem_we=1, mem_addr=addr and mem_wdata equal to the assembled word; mem_we SHALL be 0 in all other states.
REQ-012 From WRITE, if addr==last_addr the FSM SHALL go to FINISH; otherwise addr SHALL increment by 1 and the FSM SHALL go to GET_LO.
REQ-013 addr SHALL never wrap: last_addr=255 loads 256 words and terminates after writing address 255.
REQ-014 last_addr=0 SHALL load exactly one word.
REQ-015 FINISH SHALL last one cycle with done=1, then return to IDLE; done SHALL be 0 in every other state.
REQ-016 cpu_hold SHALL be 1 in GET_LO, GET_HI, WRITE and FINISH, and 0 in IDLE.
REQ-017 format_err SHALL stay set through FINISH and IDLE until the next accepted start or reset.
REQ-018 Minimum latency per word SHALL be 3 cycles (lo accept, hi accept, write), giving back-to-back throughput of 1 word per 3 cycles.
REQ-019 mem_addr and mem_wdata SHALL hold their last values outside WRITE; they are meaningful only while mem_we=1.

Reset
REQ-020 While rst_n=0 at a rising edge, the block SHALL enter IDLE and clear addr, the latched last_addr, the assembled word and format_err to 0; outputs then read byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, format_err=0.
REQ-021 Reset asserted mid-load, including during WRITE, SHALL take effect at that edge; no further write SHALL occur, and partially loaded memory contents are not restored.
REQ-022 Reset SHALL take priority over start asserted on the same edge.

Verification
REQ-023 Single word: start with last_addr=0, then bytes 0x41, 0x02 -> one mem_we pulse with addr 0 and wdata 10'b1001000001, done pulse 1 cycle later, format_err=0.
REQ-024 Three words with byte_valid gapped randomly -> writes to addr 0,1,2 in order with correct data, no extra mem_we, cpu_hold high from the cycle after start until done.
REQ-025 Full load: last_addr=255, 512 bytes back-to-back -> 256 writes, the last at addr 255, no wrap to 0, 768 cycles from first byte accept to done.
REQ-026 Malformed high byte 0xFE -> word written with bits[9:8]=2'b10, format_err=1 sticky after done; the next start clears it.
REQ-027 Reset at the WRITE cycle of word 5 -> mem_we=0 the following cycle, IDLE, all outputs at reset values; start ignored while busy (pulse during GET_HI has no effect).

Source files
------------

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-serial loader that assembles instruction words and writes them to memory
module program_loader #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  last_addr,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               cpu_hold,
    output logic               done,
    output logic               format_err
);

    localparam int HI_W = INSTR_W - 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_LO,
        S_GET_HI,
        S_WRITE,
        S_FINISH
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  r_last;
    logic [7:0]         r_lo;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [INSTR_W-1:0] r_mem_wdata;
    logic               r_err;
    logic               w_accept;

    assign w_accept = byte_valid && byte_ready;

    always_comb begin
        w_next     = r_state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        cpu_hold   = 1'b1;
        done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                cpu_hold = 1'b0;
                if (start) w_next = S_GET_LO;
            end
            S_GET_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) w_next = S_GET_HI;
            end
            S_GET_HI: begin
                byte_ready = 1'b1;
                if (byte_valid) w_next = S_WRITE;
            end
            S_WRITE: begin
                mem_we = 1'b1;
                w_next = (r_addr == r_last) ? S_FINISH : S_GET_LO;
            end
            S_FINISH: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The write port is loaded on the high-byte accept so it stays stable across
    // the address increment that follows each write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_last      <= '0;
            r_lo        <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_last <= last_addr;
                        r_addr <= '0;
                        r_err  <= 1'b0;
                    end
                end
                S_GET_LO: begin
                    if (w_accept) r_lo <= byte_in;
                end
                S_GET_HI: begin
                    if (w_accept) begin
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= {byte_in[HI_W-1:0], r_lo};
                        if (|byte_in[7:HI_W]) r_err <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (r_addr != r_last) r_addr <= r_addr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign format_err = r_err;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized self-checking bench for program_loader
module tb_program_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] last_addr;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [9:0] mem_wdata;
    logic       cpu_hold;
    logic       done;
    logic       format_err;

    int tests = 0;
    int fails = 0;

    logic [7:0] stim[$];
    logic [9:0] exp_data[$];
    bit         exp_err;
    logic [7:0] got_addr[$];
    logic [9:0] got_data[$];
    int         hold_bad;
    int         first_acc;
    int         done_cyc;
    bit         timed_out;
    bit         err_at_done;
    bit         err_first;

    program_loader #(.ADDR_W(8), .INSTR_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .last_addr(last_addr),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .format_err(format_err)
    );

    always #5 clk = ~clk;

    // Reference: each pair of bytes forms one word; any high-byte bit above bit 1 is a format error.
    function automatic void build_expected();
        exp_data.delete();
        exp_err = 1'b0;
        for (int i = 0; i + 1 < stim.size(); i += 2) begin
            exp_data.push_back({stim[i+1][1:0], stim[i]});
            if (stim[i+1] > 8'd3) exp_err = 1'b1;
        end
    endfunction

    task automatic do_load(input int last, input int gap_pct, input bit poke);
        int idx = 0;
        int cyc = 0;
        int budget;
        bit fin = 1'b0;
        budget = (last + 1) * 12 + 100;
        got_addr.delete();
        got_data.delete();
        hold_bad  = 0;
        first_acc = -1;
        done_cyc  = -1;
        timed_out = 1'b0;
        @(negedge clk);
        start = 1'b1; last_addr = last[7:0]; byte_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        err_first = format_err;
        while (!fin) begin
            if (mem_we) begin
                got_addr.push_back(mem_addr);
                got_data.push_back(mem_wdata);
            end
            if (!cpu_hold) hold_bad++;
            if (done) begin
                fin = 1'b1;
                done_cyc = cyc;
                err_at_done = format_err;
            end
            start = 1'b0; byte_valid = 1'b0; byte_in = 8'($urandom);
            if (!fin && byte_ready && idx < stim.size() && int'($urandom_range(99)) >= gap_pct) begin
                byte_valid = 1'b1;
                byte_in = stim[idx];
                if (first_acc < 0) first_acc = cyc;
                if (poke && idx == 3) begin
                    start = 1'b1; last_addr = 8'd0;
                end
                idx++;
            end
            cyc++;
            if (!fin && cyc > budget) begin
                timed_out = 1'b1;
                fin = 1'b1;
            end
            @(negedge clk);
        end
        byte_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; byte_valid = 1'b1; byte_in = 8'hFF; last_addr = 8'h12;
        repeat (2) @(negedge clk);
        tests++;
        if ({byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, format_err} !== 23'd0) begin
            fails++;
            $display("FAIL reset_outputs: got br=%b we=%b a=%0d d=%0d hold=%b done=%b err=%b, want all 0",
                     byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, format_err);
        end
        rst_n = 1'b1; start = 1'b0; byte_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (cpu_hold !== 1'b0) begin
            fails++; $display("FAIL reset_idle: cpu_hold=%b want 0", cpu_hold);
        end
    endtask

    task automatic test_single();
        stim = '{8'h41, 8'h02};
        do_load(0, 0, 1'b0);
        tests++;
        if (timed_out || got_addr.size() != 1) begin
            fails++; $display("FAIL single_count: timeout=%b writes=%0d want 1", timed_out, got_addr.size());
        end else begin
            tests++;
            if (got_addr[0] !== 8'd0 || got_data[0] !== 10'b1001000001) begin
                fails++; $display("FAIL single_word: addr=%0d data=%b want 0 1001000001", got_addr[0], got_data[0]);
            end
        end
        tests++;
        if (done_cyc - first_acc != 3) begin
            fails++; $display("FAIL single_latency: got %0d want 3", done_cyc - first_acc);
        end
        tests++;
        if (err_at_done !== 1'b0 || done !== 1'b0 || cpu_hold !== 1'b0) begin
            fails++; $display("FAIL single_after: err=%b done=%b hold=%b want 0 0 0", err_at_done, done, cpu_hold);
        end
    endtask

    task automatic test_gapped();
        stim.delete();
        for (int i = 0; i < 6; i++) stim.push_back((i % 2) ? 8'($urandom_range(3)) : 8'($urandom));
        build_expected();
        do_load(2, 40, 1'b0);
        tests++;
        if (timed_out || got_addr.size() != 3) begin
            fails++; $display("FAIL gapped_count: timeout=%b writes=%0d want 3", timed_out, got_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (got_addr[i] !== 8'(i) || got_data[i] !== exp_data[i]) begin
                    fails++; $display("FAIL gapped_word%0d: addr=%0d data=%h want %0d %h", i, got_addr[i], got_data[i], i, exp_data[i]);
                end
            end
        end
        tests++;
        if (hold_bad != 0 || err_at_done !== 1'b0) begin
            fails++; $display("FAIL gapped_hold: hold drops=%0d err=%b want 0 0", hold_bad, err_at_done);
        end
    endtask

    task automatic test_full();
        int extra = 0;
        stim.delete();
        for (int i = 0; i < 512; i++) stim.push_back(8'($urandom));
        build_expected();
        do_load(255, 0, 1'b0);
        tests++;
        if (timed_out || got_addr.size() != 256) begin
            fails++; $display("FAIL full_count: timeout=%b writes=%0d want 256", timed_out, got_addr.size());
        end else begin
            int bad = 0;
            for (int i = 0; i < 256; i++)
                if (got_addr[i] !== 8'(i) || got_data[i] !== exp_data[i]) bad++;
            tests++;
            if (bad != 0) begin
                fails++; $display("FAIL full_words: %0d wrong writes want 0", bad);
            end
        end
        tests++;
        if (done_cyc - first_acc != 768) begin
            fails++; $display("FAIL full_latency: got %0d want 768", done_cyc - first_acc);
        end
        tests++;
        if (err_at_done !== exp_err) begin
            fails++; $display("FAIL full_err: got %b want %b", err_at_done, exp_err);
        end
        repeat (5) begin
            if (mem_we) extra++;
            @(negedge clk);
        end
        tests++;
        if (extra != 0) begin
            fails++; $display("FAIL full_nowrap: %0d writes after done want 0", extra);
        end
    endtask

    task automatic test_format_err();
        stim = '{8'h33, 8'hFE, 8'h10, 8'h01};
        do_load(1, 20, 1'b0);
        tests++;
        if (got_data.size() != 2 || got_data[0] !== 10'h233 || got_data[1] !== 10'h110) begin
            fails++; $display("FAIL fmt_words: n=%0d d0=%h want 2 233 110", got_data.size(),
                              got_data.size() > 0 ? got_data[0] : 10'h0);
        end
        tests++;
        if (err_at_done !== 1'b1) begin
            fails++; $display("FAIL fmt_err_done: got %b want 1", err_at_done);
        end
        repeat (4) @(negedge clk);
        tests++;
        if (format_err !== 1'b1) begin
            fails++; $display("FAIL fmt_sticky: got %b want 1", format_err);
        end
        stim = '{8'h5A, 8'h01};
        do_load(0, 0, 1'b0);
        tests++;
        if (err_first !== 1'b0 || err_at_done !== 1'b0) begin
            fails++; $display("FAIL fmt_clear: after start=%b at done=%b want 0 0", err_first, err_at_done);
        end
    endtask

    task automatic test_start_ignored();
        stim.delete();
        for (int i = 0; i < 8; i++) stim.push_back((i % 2) ? 8'($urandom_range(3)) : 8'($urandom));
        build_expected();
        do_load(3, 0, 1'b1);
        tests++;
        if (timed_out || got_addr.size() != 4) begin
            fails++; $display("FAIL busy_start_count: timeout=%b writes=%0d want 4", timed_out, got_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (got_addr[i] !== 8'(i) || got_data[i] !== exp_data[i]) begin
                    fails++; $display("FAIL busy_start_word%0d: addr=%0d data=%h want %0d %h", i, got_addr[i], got_data[i], i, exp_data[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int idx = 0;
        int writes = 0;
        int cyc = 0;
        int late = 0;
        bit hit = 1'b0;
        stim.delete();
        for (int i = 0; i < 20; i++) stim.push_back(8'($urandom));
        @(negedge clk);
        start = 1'b1; last_addr = 8'd9;
        @(negedge clk);
        start = 1'b0;
        while (!hit && cyc < 200) begin
            byte_valid = 1'b0;
            if (mem_we) begin
                writes++;
                if (mem_addr == 8'd5) hit = 1'b1;
            end
            if (hit) begin
                rst_n = 1'b0; start = 1'b1; last_addr = 8'd2;
            end else if (byte_ready && idx < stim.size()) begin
                byte_valid = 1'b1; byte_in = stim[idx]; idx++;
            end
            cyc++;
            @(negedge clk);
        end
        tests++;
        if (!hit || writes != 6) begin
            fails++; $display("FAIL midreset_reach: hit=%b writes=%0d want 1 6", hit, writes);
        end
        tests++;
        if ({byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, format_err} !== 23'd0) begin
            fails++;
            $display("FAIL midreset_outputs: br=%b we=%b a=%0d d=%0d hold=%b done=%b err=%b want all 0",
                     byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, format_err);
        end
        rst_n = 1'b1; start = 1'b0; byte_valid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (mem_we || cpu_hold) late++;
        end
        byte_valid = 1'b0;
        tests++;
        if (late != 0) begin
            fails++; $display("FAIL midreset_idle: %0d busy cycles after reset want 0", late);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; last_addr = 8'd0; byte_in = 8'd0; byte_valid = 1'b0;
        test_reset();
        test_single();
        test_gapped();
        test_full();
        test_format_err();
        test_start_ignored();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
